// File: rtl/exe_md_stage_if.sv
// exe_md_stage_if: EX-stage bundle between the ID/EX register, the hazard unit
// and the EX/MEM register.
//   master: drives operands, immediate, destination candidates, ALU/MD controls
//           and e_md_use; observes alu_result, mrd, mb, md_busy, md_stall, hi, lo.
//   slave : the execute stage itself (the reverse directions).
interface exe_md_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] e_a;
  logic [DATA_W-1:0] e_b;
  logic [DATA_W-1:0] e_imm;
  logic [4:0]        e_rt;
  logic [4:0]        e_rd;
  logic              e_alu_src_b;
  logic              e_reg_des;
  logic              e_pc_to_reg;
  logic [4:0]        e_alu_ctrl;
  logic              md_start;
  logic [2:0]        md_op;
  logic              e_md_use;
  logic [DATA_W-1:0] alu_result;
  logic [4:0]        mrd;
  logic [DATA_W-1:0] mb;
  logic              md_busy;
  logic              md_stall;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output e_a, e_b, e_imm, e_rt, e_rd, e_alu_src_b, e_reg_des, e_pc_to_reg,
           e_alu_ctrl, md_start, md_op, e_md_use,
    input  alu_result, mrd, mb, md_busy, md_stall, hi, lo
  );

  modport slave (
    input  e_a, e_b, e_imm, e_rt, e_rd, e_alu_src_b, e_reg_des, e_pc_to_reg,
           e_alu_ctrl, md_start, md_op, e_md_use,
    output alu_result, mrd, mb, md_busy, md_stall, hi, lo
  );
endinterface

// File: rtl/exe_md_stage.sv
// exe_md_stage: pipeline execute stage. Combinational ALU with operand-B and
// destination select, plus a multi-cycle multiply/divide unit owning HI/LO.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - exe_md_stage_if.slave: operands/controls in; alu_result, mrd, mb
//           (combinational), md_busy, hi, lo (registered), md_stall (comb.)
module exe_md_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input logic           clk,
  input logic           reset,
  exe_md_stage_if.slave bus
);

  localparam int unsigned SH_W    = $clog2(DATA_W);
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;       // [1]: divide, [0]: unsigned
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic [DATA_W-1:0] op_b;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] alu_c;

  // ALU with operand-B select
  always_comb begin
    op_b  = bus.e_alu_src_b ? bus.e_b : bus.e_imm;
    shamt = op_b[SH_W-1:0];
    alu_c = '0;
    case (bus.e_alu_ctrl)
      5'd0:    alu_c = bus.e_a + op_b;
      5'd1:    alu_c = bus.e_a - op_b;
      5'd2:    alu_c = bus.e_a & op_b;
      5'd3:    alu_c = bus.e_a | op_b;
      5'd4:    alu_c = bus.e_a ^ op_b;
      5'd5:    alu_c = ~(bus.e_a | op_b);
      5'd6:    alu_c = bus.e_a << shamt;
      5'd7:    alu_c = bus.e_a >> shamt;
      5'd8:    alu_c = $signed(bus.e_a) >>> shamt;
      5'd9:    alu_c = DATA_W'($signed(bus.e_a) < $signed(op_b));
      5'd10:   alu_c = DATA_W'(bus.e_a < op_b);
      5'd11:   alu_c = op_b << (DATA_W / 2);
      5'd12:   alu_c = hi_q;
      5'd13:   alu_c = lo_q;
      default: alu_c = '0;
    endcase
  end

  assign bus.alu_result = alu_c;
  assign bus.mrd        = bus.e_reg_des   ? bus.e_rd :
                          bus.e_pc_to_reg ? 5'd31    : bus.e_rt;
  assign bus.mb         = bus.e_b;
  assign bus.md_busy    = (state_q == S_BUSY);
  assign bus.md_stall   = (state_q == S_BUSY) & bus.e_md_use;
  assign bus.hi         = hi_q;
  assign bus.lo         = lo_q;

  // MD results from the latched operands; only consumed on the commit edge
  logic signed [2*DATA_W-1:0] prod_s;
  logic        [2*DATA_W-1:0] prod_u;
  logic        [DATA_W-1:0]   quo;
  logic        [DATA_W-1:0]   rem;

  always_comb begin
    prod_s = $signed({{DATA_W{a_q[DATA_W-1]}}, a_q}) *
             $signed({{DATA_W{b_q[DATA_W-1]}}, b_q});
    prod_u = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    quo    = '1;
    rem    = a_q;
    if (b_q == '0) begin
      quo = '1;
      rem = a_q;
    end else if (op_q[0]) begin
      quo = a_q / b_q;
      rem = a_q % b_q;
    end else if ((a_q == MIN_VAL) && (b_q == '1)) begin
      // quotient overflow: wraps to MIN with zero remainder
      quo = MIN_VAL;
      rem = '0;
    end else begin
      quo = $signed(a_q) / $signed(b_q);
      rem = $signed(a_q) % $signed(b_q);
    end
  end

  // MD FSM next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (bus.md_start) begin
          case (bus.md_op)
            3'd0, 3'd1: begin
              a_d     = bus.e_a;
              b_d     = bus.e_b;
              op_d    = bus.md_op[1:0];
              cnt_d   = CNT_W'(MUL_LAT - 1);
              state_d = S_BUSY;
            end
            3'd2, 3'd3: begin
              a_d     = bus.e_a;
              b_d     = bus.e_b;
              op_d    = bus.md_op[1:0];
              cnt_d   = CNT_W'(DIV_LAT - 1);
              state_d = S_BUSY;
            end
            3'd4:    hi_d = bus.e_a;
            3'd5:    lo_d = bus.e_a;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        // md_start is ignored here, including on the commit edge
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          if (op_q[1]) begin
            hi_d = rem;
            lo_d = quo;
          end else if (op_q[0]) begin
            hi_d = prod_u[2*DATA_W-1:DATA_W];
            lo_d = prod_u[DATA_W-1:0];
          end else begin
            hi_d = prod_s[2*DATA_W-1:DATA_W];
            lo_d = prod_s[DATA_W-1:0];
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // MD state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_exe_md_stage.sv
// tb_exe_md_stage: self-checking bench for exe_md_stage. A 32-bit instance
// (MUL_LAT=5, DIV_LAT=10) and a 16-bit instance (MUL_LAT=1). Expected HI/LO
// pairs are queued when an md op starts and popped when md_busy falls.
module tb_exe_md_stage;

  logic clk;
  logic reset;

  exe_md_stage_if #(.DATA_W(32)) bus32 ();
  exe_md_stage_if #(.DATA_W(16)) bus16 ();

  exe_md_stage #(.DATA_W(32), .MUL_LAT(5), .DIV_LAT(10)) u_dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32)
  );

  exe_md_stage #(.DATA_W(16), .MUL_LAT(1), .DIV_LAT(10)) u_dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] sb_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference {hi,lo} for the 32-bit unit, via 64-bit and sign/magnitude math
  function automatic logic [63:0] md_ref(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb;
    logic [31:0] ma, mbv, q, r;
    md_ref = '0;
    case (op)
      3'd0: begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        md_ref = 64'(sa * sb);
      end
      3'd1: md_ref = {32'h0, a} * {32'h0, b};
      3'd2: begin
        if (b == 32'h0) md_ref = {a, 32'hFFFF_FFFF};
        else begin
          ma  = a[31] ? (32'h0 - a) : a;
          mbv = b[31] ? (32'h0 - b) : b;
          q   = ma / mbv;
          r   = ma % mbv;
          if (a[31] ^ b[31]) q = 32'h0 - q;
          if (a[31]) r = 32'h0 - r;
          md_ref = {r, q};
        end
      end
      3'd3: md_ref = (b == 32'h0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default: md_ref = '0;
    endcase
  endfunction

  task automatic idle32();
    bus32.e_a = '0; bus32.e_b = '0; bus32.e_imm = '0;
    bus32.e_rt = '0; bus32.e_rd = '0;
    bus32.e_alu_src_b = 1'b1; bus32.e_reg_des = 1'b0; bus32.e_pc_to_reg = 1'b0;
    bus32.e_alu_ctrl = '0; bus32.md_start = 1'b0; bus32.md_op = '0; bus32.e_md_use = 1'b0;
  endtask

  task automatic idle16();
    bus16.e_a = '0; bus16.e_b = '0; bus16.e_imm = '0;
    bus16.e_rt = '0; bus16.e_rd = '0;
    bus16.e_alu_src_b = 1'b1; bus16.e_reg_des = 1'b0; bus16.e_pc_to_reg = 1'b0;
    bus16.e_alu_ctrl = '0; bus16.md_start = 1'b0; bus16.md_op = '0; bus16.e_md_use = 1'b0;
  endtask

  task automatic alu_vec(input string tag, input logic [4:0] ctrl, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    bus32.e_alu_src_b = 1'b1;
    bus32.e_alu_ctrl  = ctrl;
    bus32.e_a         = a;
    bus32.e_b         = b;
    #1;
    chk(tag, 64'(bus32.alu_result), 64'(exp));
  endtask

  // Start an md op on the 32-bit unit; optionally keep asserting mtlo while busy
  // (including the commit cycle), which must be ignored.
  task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat,
                        input bit intrude);
    logic [63:0] e;
    int          n;
    sb_q.push_back(exp);
    bus32.md_start = 1'b1;
    bus32.md_op    = op;
    bus32.e_a      = a;
    bus32.e_b      = b;
    bus32.e_md_use = 1'b0;
    tick();
    bus32.md_start = intrude;
    bus32.md_op    = 3'd5;
    bus32.e_a      = 32'hA5A5_A5A5;
    n = 0;
    while (bus32.md_busy && n < 100) begin
      n++;
      tick();
    end
    bus32.md_start = 1'b0;
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    e = sb_q.pop_front();
    chk({tag, "_hilo"}, {bus32.hi, bus32.lo}, e);
  endtask

  task automatic md16_run(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [31:0] exp);
    logic [63:0] e;
    int          n;
    sb_q.push_back(64'(exp));
    bus16.md_start = 1'b1;
    bus16.md_op    = op;
    bus16.e_a      = a;
    bus16.e_b      = b;
    tick();
    bus16.md_start = 1'b0;
    n = 0;
    while (bus16.md_busy && n < 100) begin
      n++;
      tick();
    end
    chk({tag, "_pulse"}, 64'(n), 64'd1);
    e = sb_q.pop_front();
    chk({tag, "_hilo"}, 64'({bus16.hi, bus16.lo}), e);
  endtask

  initial begin
    int          n;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    logic [63:0] e;

    reset = 1'b1;
    idle32();
    idle16();
    #1;
    chk("rst_hi", 64'(bus32.hi), 64'h0);
    chk("rst_lo", 64'(bus32.lo), 64'h0);
    chk("rst_busy", 64'(bus32.md_busy), 64'h0);
    #3 reset = 1'b0;
    tick();

    // ALU paths
    alu_vec("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001);
    alu_vec("sub",      5'd1, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE);
    alu_vec("and",      5'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu_vec("or",       5'd3, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    alu_vec("xor",      5'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    alu_vec("nor",      5'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F);
    alu_vec("sll_mask", 5'd6, 32'h0000_0001, 32'h0000_0024, 32'h0000_0010);
    alu_vec("srl",      5'd7, 32'h8000_0000, 32'h0000_0004, 32'h0800_0000);
    alu_vec("sra",      5'd8, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000);
    alu_vec("slt",      5'd9, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001);
    alu_vec("sltu",     5'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    alu_vec("lui",      5'd11, 32'h1111_1111, 32'h0000_1234, 32'h1234_0000);
    alu_vec("ctrl20",   5'd20, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000);

    bus32.e_alu_src_b = 1'b0;
    bus32.e_alu_ctrl  = 5'd0;
    bus32.e_a         = 32'h1;
    bus32.e_imm       = 32'h3;
    bus32.e_b         = 32'h100;
    #1;
    chk("add_imm", 64'(bus32.alu_result), 64'h4);
    chk("mb", 64'(bus32.mb), 64'h100);
    bus32.e_alu_src_b = 1'b1;

    bus32.e_rt = 5'd5;
    bus32.e_rd = 5'd9;
    bus32.e_reg_des = 1'b1; bus32.e_pc_to_reg = 1'b0; #1;
    chk("mrd_rd", 64'(bus32.mrd), 64'd9);
    bus32.e_reg_des = 1'b0; bus32.e_pc_to_reg = 1'b1; #1;
    chk("mrd_31", 64'(bus32.mrd), 64'd31);
    bus32.e_reg_des = 1'b0; bus32.e_pc_to_reg = 1'b0; #1;
    chk("mrd_rt", 64'(bus32.mrd), 64'd5);
    bus32.e_reg_des = 1'b1; bus32.e_pc_to_reg = 1'b1; #1;
    chk("mrd_rd_pri", 64'(bus32.mrd), 64'd9);
    idle32();
    tick();

    // mthi/mtlo and mfhi/mflo
    bus32.md_start = 1'b1; bus32.md_op = 3'd4; bus32.e_a = 32'h0000_1234;
    tick();
    bus32.md_op = 3'd5; bus32.e_a = 32'h0000_5678;
    tick();
    bus32.md_start = 1'b0;
    chk("mthi", 64'(bus32.hi), 64'h1234);
    chk("mtlo", 64'(bus32.lo), 64'h5678);
    chk("mthi_nobusy", 64'(bus32.md_busy), 64'h0);
    bus32.e_alu_ctrl = 5'd12; #1;
    chk("mfhi", 64'(bus32.alu_result), 64'h1234);
    bus32.e_alu_ctrl = 5'd13; #1;
    chk("mflo", 64'(bus32.alu_result), 64'h5678);
    bus32.md_start = 1'b1; bus32.md_op = 3'd6; bus32.e_a = 32'hDEAD_BEEF;
    tick();
    bus32.md_start = 1'b0;
    chk("nop6_hi", {bus32.hi, bus32.lo}, 64'h0000_1234_0000_5678);
    chk("nop6_busy", 64'(bus32.md_busy), 64'h0);

    // Reset mid-operation
    bus32.md_start = 1'b1; bus32.md_op = 3'd0; bus32.e_a = 32'h3; bus32.e_b = 32'h4;
    tick();
    bus32.md_start = 1'b0;
    tick();
    chk("busy_mid", 64'(bus32.md_busy), 64'h1);
    bus32.e_md_use = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_hi", 64'(bus32.hi), 64'h0);
    chk("rst_mid_lo", 64'(bus32.lo), 64'h0);
    chk("rst_mid_busy", 64'(bus32.md_busy), 64'h0);
    chk("rst_mid_stall", 64'(bus32.md_stall), 64'h0);
    #2 reset = 1'b0;
    bus32.e_md_use = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("rst_discard", {bus32.hi, bus32.lo}, 64'h0);

    // Multiply / divide with latency and boundaries
    md_run("mult",     3'd0, 32'hFFFF_FFFF, 32'h2, 64'hFFFF_FFFF_FFFF_FFFE, 5, 1'b0);
    md_run("multu",    3'd1, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, 5, 1'b1);
    md_run("div",      3'd2, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, 10, 1'b0);
    md_run("divu_z",   3'd3, 32'h7, 32'h0, 64'h0000_0007_FFFF_FFFF, 10, 1'b1);
    md_run("div_z",    3'd2, 32'hFFFF_FFFB, 32'h0, 64'hFFFF_FFFB_FFFF_FFFF, 10, 1'b0);
    md_run("div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10, 1'b0);
    md_run("div_m7_m2", 3'd2, 32'h7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 10, 1'b0);
    for (int i = 0; i < 4; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 0) ? 32'h0000_0013 : $urandom;
      md_run("md_rand", rop, ra, rb, md_ref(rop, ra, rb), (rop < 3'd2) ? 5 : 10, 1'b1);
    end

    // Stall: mflo one cycle after the mult start cycle
    ra = 32'h0001_2345;
    rb = 32'h0001_0001;
    sb_q.push_back(md_ref(3'd0, ra, rb));
    bus32.md_start = 1'b1; bus32.md_op = 3'd0; bus32.e_a = ra; bus32.e_b = rb;
    tick();
    bus32.md_start = 1'b0;
    bus32.e_md_use = 1'b0;
    #1;
    chk("stall_nouse", 64'(bus32.md_stall), 64'h0);
    tick();
    bus32.e_md_use   = 1'b1;
    bus32.e_alu_ctrl = 5'd13;
    #1;
    n = 0;
    while (bus32.md_stall && n < 100) begin
      n++;
      tick();
      #1;
    end
    chk("stall_cycles", 64'(n), 64'd4);
    e = sb_q.pop_front();
    chk("stall_mflo", 64'(bus32.alu_result), 64'(e[31:0]));
    bus32.e_md_use = 1'b0;

    // 16-bit instance with single-cycle multiply
    bus16.md_start = 1'b1; bus16.md_op = 3'd4; bus16.e_a = 16'hBEEF;
    tick();
    bus16.md_op = 3'd5; bus16.e_a = 16'h1357;
    tick();
    bus16.md_start = 1'b0;
    chk("w16_mthi", 64'(bus16.hi), 64'hBEEF);
    chk("w16_mtlo", 64'(bus16.lo), 64'h1357);
    md16_run("w16_mult",  3'd0, 16'hFFFF, 16'h0003, 32'hFFFF_FFFD);
    md16_run("w16_multu", 3'd1, 16'hFFFF, 16'h0003, 32'h0002_FFFD);
    md16_run("w16_mult2", 3'd0, 16'h8000, 16'h8000, 32'h4000_0000);
    bus16.e_alu_ctrl = 5'd8; bus16.e_a = 16'h8000; bus16.e_b = 16'h0014;
    #1;
    chk("w16_sra", 64'(bus16.alu_result), 64'hF800);

    if (sb_q.size() != 0) chk("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
